// File: rtl/fb_pkg.sv
// fb_pkg: scanout state encoding and colour-bar constants shared by the framebuffer.
package fb_pkg;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCAN} fb_state_t;

    localparam logic [23:0] BAR_RED   = 24'hFF0000;
    localparam logic [23:0] BAR_GREEN = 24'h00FF00;
    localparam logic [23:0] BAR_BLUE  = 24'h0000FF;

    // Three equal-width vertical bars across the line.
    function automatic logic [23:0] bar_colour(input int x, input int width);
        return (x < width / 3) ? BAR_RED : (x < 2 * width / 3) ? BAR_GREEN : BAR_BLUE;
    endfunction

endpackage

// File: rtl/fb_bank.sv
// fb_bank: one framebuffer bank, single write port and one registered read port.
module fb_bank #(
    parameter int DEPTH = 76800,
    parameter int PIXEL_W = 24,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [PIXEL_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [PIXEL_W-1:0] rdata
);

    logic [PIXEL_W-1:0] mem [DEPTH];
    logic [PIXEL_W-1:0] rdata_q;

    // Read data holds when re is low, which lets scanout stall without refetching.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: double-buffered framebuffer with MMIO access to the back bank and pixel streaming of the front bank.
// Define FB_TEST_PATTERN_EN to fill both banks with colour bars after every reset.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int FRAME_WIDTH = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int PIXEL_W = 24,
    parameter int ADDR_W = 17
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [PIXEL_W-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [PIXEL_W-1:0] rsp_rdata,
    output logic               rsp_err,
    input  logic               dump_req,
    input  logic               swap_req,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIXEL_W-1:0] pix_data,
    output logic               pix_eol,
    output logic               pix_last,
    output logic               busy,
    output logic               front_sel
);

    localparam int NPIX = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int AW = $clog2(NPIX);
    localparam int XW = $clog2(FRAME_WIDTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [XW-1:0] LAST_X = XW'(FRAME_WIDTH - 1);
`ifdef FB_TEST_PATTERN_EN
    localparam fb_state_t RESET_STATE = ST_INIT;
`else
    localparam fb_state_t RESET_STATE = ST_IDLE;
`endif

    fb_state_t          state_q, state_d;
    logic               front_sel_q, front_sel_d;
    logic               swap_pend_q, swap_pend_d;
    logic [AW-1:0]      fetch_addr_q, fetch_addr_d;
    logic [XW-1:0]      fetch_x_q, fetch_x_d;
    logic               fetch_done_q, fetch_done_d;
    logic               pix_valid_q, pix_valid_d;
    logic               pix_eol_q, pix_eol_d;
    logic               pix_last_q, pix_last_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_bank_q, rsp_bank_d;
    logic               accept, in_range, mmio_wr, mmio_rd, init_wr, fetch, beat;
    logic [1:0]         bank_we, bank_re;
    logic [AW-1:0]      bank_raddr [2];
    logic [AW-1:0]      bank_waddr;
    logic [PIXEL_W-1:0] bank_wdata;
    logic [PIXEL_W-1:0] bank_rdata [2];

    assign req_ready = !reset && state_q != ST_INIT;
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < (ADDR_W + 1)'(NPIX);
    assign mmio_wr   = accept && req_we && in_range;
    assign mmio_rd   = accept && !req_we && in_range;
    assign init_wr   = !reset && state_q == ST_INIT;
    assign beat      = pix_valid_q && pix_ready;
    // Fetch the next pixel whenever the output slot is empty or being drained this cycle.
    assign fetch     = !reset && state_q == ST_SCAN && !fetch_done_q && (!pix_valid_q || pix_ready);

    // The fetch counters double as the fill counters while initialising.
    assign bank_waddr = init_wr ? fetch_addr_q : req_addr[AW-1:0];
    assign bank_wdata = init_wr ? PIXEL_W'(bar_colour(int'(fetch_x_q), FRAME_WIDTH)) : req_wdata;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic B = 1'(b);
        assign bank_we[b]    = init_wr || (mmio_wr && front_sel_q != B);
        assign bank_re[b]    = front_sel_q == B ? fetch : mmio_rd;
        assign bank_raddr[b] = front_sel_q == B ? fetch_addr_q : req_addr[AW-1:0];
        fb_bank #(.DEPTH(NPIX), .PIXEL_W(PIXEL_W)) u_bank (
            .clock (clock),
            .we    (bank_we[b]),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .re    (bank_re[b]),
            .raddr (bank_raddr[b]),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        state_d      = state_q;
        front_sel_d  = front_sel_q;
        swap_pend_d  = swap_pend_q;
        fetch_addr_d = fetch_addr_q;
        fetch_x_d    = fetch_x_q;
        fetch_done_d = fetch_done_q;
        pix_valid_d  = pix_valid_q;
        pix_eol_d    = pix_eol_q;
        pix_last_d   = pix_last_q;
        rsp_valid_d  = accept && (!req_we || !in_range);
        rsp_err_d    = accept && !in_range;
        rsp_bank_d   = !front_sel_q;
        if (init_wr || fetch) begin
            fetch_addr_d = fetch_addr_q + AW'(1);
            fetch_x_d    = fetch_x_q == LAST_X ? '0 : fetch_x_q + XW'(1);
        end
        case (state_q)
            ST_INIT: state_d = fetch_addr_q == LAST_ADDR ? ST_IDLE : ST_INIT;
            ST_IDLE: begin
                front_sel_d = front_sel_q ^ swap_req;
                if (dump_req) begin
                    state_d      = ST_SCAN;
                    fetch_addr_d = '0;
                    fetch_x_d    = '0;
                    fetch_done_d = 1'b0;
                end
            end
            ST_SCAN: begin
                swap_pend_d = swap_pend_q || swap_req;
                if (fetch) begin
                    pix_valid_d  = 1'b1;
                    pix_eol_d    = fetch_x_q == LAST_X;
                    pix_last_d   = fetch_addr_q == LAST_ADDR;
                    fetch_done_d = fetch_addr_q == LAST_ADDR;
                end else if (beat) begin
                    pix_valid_d = 1'b0;
                end
                // Swaps requested during the frame collapse into one, applied once the frame is out.
                if (beat && pix_last_q) begin
                    state_d     = ST_IDLE;
                    front_sel_d = front_sel_q ^ swap_pend_d;
                    swap_pend_d = 1'b0;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            front_sel_q  <= 1'b0;
            swap_pend_q  <= 1'b0;
            fetch_addr_q <= '0;
            fetch_x_q    <= '0;
            fetch_done_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_eol_q    <= 1'b0;
            pix_last_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_bank_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_sel_q  <= front_sel_d;
            swap_pend_q  <= swap_pend_d;
            fetch_addr_q <= fetch_addr_d;
            fetch_x_q    <= fetch_x_d;
            fetch_done_q <= fetch_done_d;
            pix_valid_q  <= pix_valid_d;
            pix_eol_q    <= pix_eol_d;
            pix_last_q   <= pix_last_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_bank_q   <= rsp_bank_d;
        end
    end

    assign rsp_valid = rsp_valid_q && !reset;
    assign rsp_err   = rsp_err_q && !reset;
    assign rsp_rdata = rsp_err_q ? '0 : bank_rdata[rsp_bank_q];
    assign pix_valid = pix_valid_q && !reset;
    assign pix_data  = bank_rdata[front_sel_q];
    assign pix_eol   = pix_eol_q;
    assign pix_last  = pix_last_q;
    assign busy      = !reset && state_q != ST_IDLE;
    assign front_sel = front_sel_q && !reset;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: random MMIO and scanout traffic checked every cycle against a frame-level model of both banks.
`timescale 1ns/1ps
module tb_fb_scanout;

    localparam int W = 320;
    localparam int H = 240;
    localparam int N = W * H;
    localparam int AW = 17;
    localparam int PW = 24;
    localparam int S_INIT = 0;
    localparam int S_IDLE = 1;
    localparam int S_SCAN = 2;
`ifdef FB_TEST_PATTERN_EN
    localparam int RST_STATE = S_INIT;
`else
    localparam int RST_STATE = S_IDLE;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [PW-1:0] req_wdata = '0;
    logic          dump_req = 1'b0;
    logic          swap_req = 1'b0;
    logic          pix_ready = 1'b1;
    logic          req_ready, rsp_valid, rsp_err, pix_valid, pix_eol, pix_last, busy, front_sel;
    logic [PW-1:0] rsp_rdata, pix_data;

    fb_scanout #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIXEL_W(PW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dump_req(dump_req), .swap_req(swap_req),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_eol(pix_eol), .pix_last(pix_last),
        .busy(busy), .front_sel(front_sel)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [23:0] bar(input int x);
        if (x < W / 3) return 24'hFF0000;
        if (x < 2 * W / 3) return 24'h00FF00;
        return 24'h0000FF;
    endfunction

    // Frame-level model: bank contents, which bank is front, and where the stream is.
    logic [PW-1:0] mem [2][N];
    bit            known [2][N];
    int            m_state = RST_STATE;
    bit            m_front = 0, m_pend = 0, m_valid = 0, m_wait = 0, m_scan_bank = 0;
    int            m_beat = 0, init_i = 0;
    bit            e_rsp_v = 0, e_rsp_e = 0, e_rsp_k = 0;
    logic [PW-1:0] e_rsp_d = '0;

    always @(posedge clock) begin
        bit acc, oor;
        acc = req_valid && !reset && m_state != S_INIT;
        oor = req_addr >= N;
        if (reset) begin
            m_state = RST_STATE;
            m_front = 0;
            m_pend = 0;
            m_valid = 0;
            m_wait = 0;
            init_i = 0;
            e_rsp_v = 0;
            e_rsp_e = 0;
        end else begin
            e_rsp_v = acc && (!req_we || oor);
            e_rsp_e = acc && oor;
            e_rsp_k = 1;
            e_rsp_d = '0;
            if (acc && !req_we && !oor) begin
                e_rsp_k = known[!m_front][req_addr];
                e_rsp_d = mem[!m_front][req_addr];
            end
            if (acc && req_we && !oor) begin
                mem[!m_front][req_addr] = req_wdata;
                known[!m_front][req_addr] = 1;
            end
            case (m_state)
                S_INIT: begin
                    for (int b = 0; b < 2; b++) begin
                        mem[b][init_i] = bar(init_i % W);
                        known[b][init_i] = 1;
                    end
                    init_i++;
                    if (init_i == N) m_state = S_IDLE;
                end
                S_IDLE: begin
                    if (swap_req) m_front = !m_front;
                    if (dump_req) begin
                        m_state = S_SCAN;
                        m_scan_bank = m_front;
                        m_wait = 1;
                        m_beat = 0;
                    end
                end
                default: begin
                    if (swap_req) m_pend = 1;
                    if (m_wait) begin
                        m_wait = 0;
                        m_valid = 1;
                    end else if (m_valid && pix_ready) begin
                        if (m_beat == N - 1) begin
                            m_valid = 0;
                            m_state = S_IDLE;
                            if (m_pend) m_front = !m_front;
                            m_pend = 0;
                        end else begin
                            m_beat++;
                        end
                    end
                end
            endcase
        end
    end

    logic [PW-1:0] prev_data = '0;
    bit            prev_stall = 0;

    always @(negedge clock) begin
        check("req_ready", req_ready, !reset && m_state != S_INIT);
        check("busy", busy, !reset && m_state != S_IDLE);
        check("front_sel", front_sel, !reset && m_front);
        check("rsp_valid", rsp_valid, !reset && e_rsp_v);
        if (!reset && e_rsp_v) begin
            check("rsp_err", rsp_err, e_rsp_e);
            if (e_rsp_k) check("rsp_rdata", rsp_rdata, e_rsp_d);
        end
        check("pix_valid", pix_valid, !reset && m_valid);
        if (!reset && m_valid) begin
            if (known[m_scan_bank][m_beat]) check("pix_data", pix_data, mem[m_scan_bank][m_beat]);
            check("pix_eol", pix_eol, m_beat % W == W - 1);
            check("pix_last", pix_last, m_beat == N - 1);
            if (prev_stall) check("pix_hold", pix_data, prev_data);
        end
        prev_stall = !reset && pix_valid && !pix_ready;
        prev_data = pix_data;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        req_valid = 0;
        req_we = 0;
        dump_req = 0;
        swap_req = 0;
    endtask

    task automatic mmio(input bit we, input logic [AW-1:0] a, input logic [PW-1:0] d);
        req_valid = 1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        tick();
        req_valid = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, beats, eols, cyc;
        bit last_seen;
        repeat (3) tick();
        reset = 0;
`ifdef FB_TEST_PATTERN_EN
        cnt = 0;
        @(negedge clock);
        while (busy && cnt < N + 10) begin
            cnt++;
            @(negedge clock);
        end
        check("init_busy_cycles", cnt, N);
        tick();
`else
        #1;
        check("reset_front_sel", front_sel, 0);
        check("reset_busy", busy, 0);
        check("reset_req_ready", req_ready, 1);
`endif
        mmio(1, 5, 24'h123456);
        check("wr_no_rsp", rsp_valid, 0);
        mmio(0, 5, 0);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rdata", rsp_rdata, 24'h123456);
        check("rd_err", rsp_err, 0);
        mmio(1, AW'(N), 24'hDEAD01);
        check("oor_wr_valid", rsp_valid, 1);
        check("oor_wr_err", rsp_err, 1);
        tick();
        check("oor_rsp_one_cycle", rsp_valid, 0);
        mmio(0, AW'(N), 0);
        check("oor_rd_err", rsp_err, 1);
        check("oor_rd_data", rsp_rdata, 0);
        mmio(0, 5, 0);
        check("rd_after_oor", rsp_rdata, 24'h123456);
`ifdef FB_TEST_PATTERN_EN
        dump_req = 1;
        tick();
        dump_req = 0;
        tick();
        for (int x = 0; x < W; x++) begin
            if (x == 0) check("bar_x0", pix_data, 24'hFF0000);
            if (x == 120) check("bar_x120", pix_data, 24'h00FF00);
            if (x == 300) check("bar_x300", pix_data, 24'h0000FF);
            tick();
        end
`else
        for (int i = 0; i < 600; i++) mmio(1, AW'(i), PW'($urandom));
        for (int i = 0; i < 200; i++) mmio(1, AW'($urandom_range(0, N - 1)), PW'($urandom));
        for (int i = 0; i < 150; i++) begin
            mmio(0, AW'($urandom_range(0, 700)), 0);
            if ($urandom_range(0, 1) == 1) tick();
        end
        mmio(1, 0, 24'hABCDEF);
        check("pre_swap_front", front_sel, 0);
        swap_req = 1;
        tick();
        swap_req = 0;
        check("swap_front", front_sel, 1);
        dump_req = 1;
        tick();
        dump_req = 0;
        check("dump_plus1_valid", pix_valid, 0);
        tick();
        check("dump_plus2_valid", pix_valid, 1);
        check("first_beat", pix_data, 24'hABCDEF);
        beats = 0;
        eols = 0;
        cyc = 0;
        last_seen = 0;
        while (!last_seen && cyc < 2 * N) begin
            pix_ready = (beats >= 2000 && beats < 3000) ? 1'($urandom_range(0, 1)) : 1'b1;
            req_valid = $urandom_range(0, 3) == 0;
            req_we = 1'($urandom_range(0, 1));
            req_addr = AW'($urandom_range(0, N - 1));
            req_wdata = PW'($urandom);
            swap_req = beats == 100 || (beats >= 5000 && beats < 5003);
            dump_req = beats == 50;
            if (pix_valid && pix_ready) begin
                beats++;
                if (pix_eol) eols++;
                if (pix_last) begin
                    last_seen = 1;
                    check("last_beat_index", beats, N);
                end
            end
            tick();
            cyc++;
        end
        idle_in();
        pix_ready = 1;
        check("scan_completed", last_seen, 1);
        check("scan_beats", beats, N);
        check("scan_eols", eols, H);
        check("swap_after_last", front_sel, 0);
        check("scan_end_busy", busy, 0);
        tick();
        check("single_toggle", front_sel, 0);
        dump_req = 1;
        swap_req = 1;
        tick();
        idle_in();
        check("dual_front", front_sel, 1);
        tick();
        check("dual_first_beat", pix_data, 24'hABCDEF);
        repeat (40) tick();
        reset = 1;
        tick();
        check("abort_valid", pix_valid, 0);
        reset = 0;
        repeat (20) tick();
        check("abort_front", front_sel, 0);
        check("abort_busy", busy, 0);
        req_valid = 1;
        req_we = 1;
        req_addr = 7;
        req_wdata = 24'h777777;
        swap_req = 1;
        tick();
        idle_in();
        swap_req = 1;
        tick();
        swap_req = 0;
        mmio(0, 7, 0);
        check("swap_write_bank", rsp_rdata, 24'h777777);
`endif
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
